rv_imem: RTL and testbench

Instruction-memory responder for the fetch port of the RV32 core. It sits on the far side of the fetch unit's instruction bus and answers each `i_cyc`/`i_addr` request with a one-cycle `o_ack`. The fetched word follows one cycle later on `o_instruction`. It wraps a word-organised synchronous RAM with a programmable wait-state count and a side write port for program loading.

---
 rtl/rv_bus_pkg.sv | 17 +
 rtl/rv_imem_ram.sv | 32 +++
 rtl/rv_imem.sv | 116 +++++++++++
 tb/tb_rv_imem.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_bus_pkg.sv
// Shared constants for the RV32 instruction bus: data width, wait-counter
// width, default fault word and the byte-address to word-index helper.
package rv_bus_pkg;

    localparam int          XLEN               = 32;
    localparam int          WAIT_W             = 4;
    localparam logic [31:0] DEFAULT_FAULT_WORD = 32'h0000_0000;

    // The subtraction is plain 32-bit modular. The caller qualifies the
    // result with an addr >= base check, so an address below base never
    // produces a wrapped index.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/rv_imem_ram.sv
// 1R1W word-organised synchronous RAM with a registered read and no reset.
// A read during a write to the same word returns the old contents.
module rv_imem_ram
    import rv_bus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rv_imem.sv
// Fetch-port instruction memory: wait-state counter and window decode in
// front of rv_imem_ram, plus the write-first bypass and fault muxing.
module rv_imem
    import rv_bus_pkg::*;
#(
    parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000,
    parameter int              MEM_WORDS   = 1024,
    parameter int              WAIT_STATES = 0,
    parameter logic [XLEN-1:0] FAULT_WORD  = DEFAULT_FAULT_WORD
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_cyc,
    input  logic [31:0]     i_addr,
    output logic            o_ack,
    output logic [XLEN-1:0] o_instruction,
    output logic            o_fault,
    input  logic            i_we,
    input  logic [31:0]     i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    localparam int                AW       = $clog2(MEM_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_CNT = WAIT_W'(WAIT_STATES);

    logic              busy_q, busy_d;
    logic [29:0]       addr_q, addr_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              byp_q, byp_d;
    logic [XLEN-1:0]   byp_data_q, byp_data_d;

    logic [31:0]       r_idx, w_idx;
    logic              r_in_win, w_in_win, byp_hit, ack;
    logic [WAIT_W-1:0] cur;
    logic [XLEN-1:0]   ram_rdata;

    assign r_idx    = word_index(i_addr, BASE_ADDR);
    assign w_idx    = word_index(i_waddr, BASE_ADDR);
    assign r_in_win = (i_addr >= BASE_ADDR) && (r_idx < 32'(MEM_WORDS));
    assign w_in_win = (i_waddr >= BASE_ADDR) && (w_idx < 32'(MEM_WORDS));
    assign byp_hit  = i_we && w_in_win && r_in_win && (w_idx == r_idx);

    // A different address than the one being counted restarts from zero.
    assign cur = (busy_q && (i_addr[31:2] == addr_q)) ? cnt_q : '0;
    assign ack = i_cyc && !i_reset && (cur == WAIT_CNT);

    always_comb begin
        busy_d     = busy_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;

        if (i_reset || !i_cyc || ack) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else begin
            busy_d = 1'b1;
            addr_d = i_addr[31:2];
            cnt_d  = cur + 1'b1;
        end

        if (ack) begin
            valid_d    = 1'b1;
            fault_d    = !r_in_win;
            byp_d      = byp_hit;
            byp_data_d = i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    // The RAM is read only on an in-window ack, so its output register holds
    // the last fetched word while no further ack arrives.
    rv_imem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (i_we && w_in_win),
        .waddr (w_idx[AW-1:0]),
        .wdata (i_wdata),
        .re    (ack && r_in_win),
        .raddr (r_idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign o_ack         = ack;
    assign o_fault       = fault_q;
    assign o_instruction = !valid_q ? '0         :
                           fault_q  ? FAULT_WORD :
                           byp_q    ? byp_data_q : ram_rdata;

endmodule

// File: tb/tb_rv_imem.sv
// Bench for rv_imem: two instances (0 waits at base 0, 3 waits at base 0x1000)
// share one stimulus stream and are checked against a per-instance model.
module tb_rv_imem;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cyc = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_we = 1'b0;
    logic [31:0] i_waddr = '0;
    logic [31:0] i_wdata = '0;

    logic        ack_a, ack_b, fault_a, fault_b;
    logic [31:0] instr_a, instr_b;

    always #5 clk = ~clk;

    rv_imem #(
        .BASE_ADDR (32'h0000_0000), .MEM_WORDS (16),
        .WAIT_STATES (0), .FAULT_WORD (32'h0000_0000)
    ) dut_a (
        .i_clk (clk), .i_reset (i_reset), .i_cyc (i_cyc), .i_addr (i_addr),
        .o_ack (ack_a), .o_instruction (instr_a), .o_fault (fault_a),
        .i_we (i_we), .i_waddr (i_waddr), .i_wdata (i_wdata)
    );

    rv_imem #(
        .BASE_ADDR (32'h0000_1000), .MEM_WORDS (32),
        .WAIT_STATES (3), .FAULT_WORD (32'hBAD0_BAD0)
    ) dut_b (
        .i_clk (clk), .i_reset (i_reset), .i_cyc (i_cyc), .i_addr (i_addr),
        .o_ack (ack_b), .o_instruction (instr_b), .o_fault (fault_b),
        .i_we (i_we), .i_waddr (i_waddr), .i_wdata (i_wdata)
    );

    // Reference model: per-instance parameters, memory image, and how many
    // consecutive cycles the current address has been requested unacked.
    int unsigned W     [2] = '{0, 3};
    logic [31:0] BASE  [2] = '{32'h0000_0000, 32'h0000_1000};
    int unsigned WORDS [2] = '{16, 32};
    logic [31:0] FW    [2] = '{32'h0000_0000, 32'hBAD0_BAD0};

    logic [31:0] mmem    [2][32];
    int unsigned age     [2];
    bit          pend_v  [2];
    logic [29:0] pend_a  [2];
    logic [31:0] e_instr [2];
    bit          e_fault [2];
    bit          e_ack   [2];
    bit          seen_ack[2];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle_no = 0;
    bit verbose  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %08h expected %08h", tag, cycle_no, got, exp);
    endtask

    function automatic bit in_win(input int k, input logic [31:0] a);
        return (a >= BASE[k]) && (((a - BASE[k]) >> 2) < WORDS[k]);
    endfunction

    task automatic step(input bit rst, input bit cyc, input logic [31:0] addr,
                        input bit we, input logic [31:0] waddr, input logic [31:0] wdata);
        int unsigned cur [2];
        logic [31:0] ri;
        @(negedge clk);
        i_reset = rst; i_cyc = cyc; i_addr = addr;
        i_we = we; i_waddr = waddr; i_wdata = wdata;
        #1;
        for (int k = 0; k < 2; k++) begin
            cur[k]   = (pend_v[k] && (addr[31:2] == pend_a[k])) ? age[k] : 0;
            e_ack[k] = cyc && !rst && (cur[k] == W[k]);
        end
        seen_ack[0] = ack_a;
        seen_ack[1] = ack_b;
        check("ack_a", 32'(ack_a), 32'(e_ack[0]));
        check("ack_b", 32'(ack_b), 32'(e_ack[1]));
        @(posedge clk);
        #1;
        cycle_no++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_instr[k] = '0;
                e_fault[k] = 1'b0;
            end else if (e_ack[k]) begin
                if (in_win(k, addr)) begin
                    ri = (addr - BASE[k]) >> 2;
                    e_instr[k] = (we && in_win(k, waddr) && (((waddr - BASE[k]) >> 2) == ri))
                                 ? wdata : mmem[k][ri];
                    e_fault[k] = 1'b0;
                end else begin
                    e_instr[k] = FW[k];
                    e_fault[k] = 1'b1;
                end
            end
            if (we && in_win(k, waddr)) mmem[k][(waddr - BASE[k]) >> 2] = wdata;
            if (rst || !cyc || e_ack[k]) begin
                pend_v[k] = 1'b0;
                age[k]    = 0;
            end else begin
                pend_v[k] = 1'b1;
                pend_a[k] = addr[31:2];
                age[k]    = cur[k] + 1;
            end
        end
        check("instr_a", instr_a, e_instr[0]);
        check("fault_a", 32'(fault_a), 32'(e_fault[0]));
        check("instr_b", instr_b, e_instr[1]);
        check("fault_b", 32'(fault_b), 32'(e_fault[1]));
        if (verbose && (seen_ack[0] || seen_ack[1]))
            $display("cycle %0d addr %08h ack_a %0b instr_a %08h ack_b %0b instr_b %08h fault_b %0b",
                     cycle_no, addr, seen_ack[0], instr_a, seen_ack[1], instr_b, fault_b);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'(4 * $urandom_range(0, 19));
            1:       return 32'h0000_0FF8 + 32'(4 * $urandom_range(0, 37));
            2:       return $urandom & 32'hFFFF_FFFC;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    logic [31:0] dir_data [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
    logic [31:0] ra;

    initial begin
        for (int k = 0; k < 2; k++) begin
            age[k] = 0; pend_v[k] = 1'b0; pend_a[k] = '0;
            e_instr[k] = '0; e_fault[k] = 1'b0;
        end

        // Reset state.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        check("rst_ack_b", 32'(seen_ack[1]), 32'd0);
        check("rst_instr_a", instr_a, 32'h0);
        check("rst_fault_b", 32'(fault_b), 32'd0);

        // Program load through the side port.
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 32'h0, 1'b1, 32'(4 * i), (i < 4) ? dir_data[i] : 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(4 * i), 32'hB000_0000 + 32'(i));

        // Zero waits: one word per cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'(4 * i), 1'b0, 32'h0, 32'h0);
            check("w0_ack", 32'(seen_ack[0]), 32'd1);
            check("w0_data", instr_a, dir_data[i]);
            check("w0_fault", 32'(fault_a), 32'd0);
        end
        idle();

        // Three waits, held address: ack in the 4th and 8th cycles only.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h1010, 1'b0, 32'h0, 32'h0);
            check("w3_ack", 32'(seen_ack[1]), 32'((i == 3) || (i == 7)));
            if (i == 3) check("w3_data", instr_b, 32'hB000_0004);
        end
        idle();

        // Address switch mid-wait drops the first request.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, (i < 2) ? 32'h1010 : 32'h1040, 1'b0, 32'h0, 32'h0);
            check("sw_ack", 32'(seen_ack[1]), 32'(i == 5));
        end
        check("sw_data", instr_b, 32'hB000_0010);
        idle();

        // Window boundaries on the 0x1000-based instance.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h0FFC, 1'b0, 32'h0, 32'h0);
        check("lo_fault", 32'(fault_b), 32'd1);
        check("lo_data", instr_b, 32'hBAD0_BAD0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h1080, 1'b0, 32'h0, 32'h0);
        check("hi_fault", 32'(fault_b), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
        check("base_fault", 32'(fault_b), 32'd0);
        check("base_data", instr_b, 32'hB000_0000);
        idle();

        // Write-first bypass on a same-cycle write and acked read.
        step(1'b0, 1'b1, 32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF);
        check("byp_data", instr_a, 32'hDEAD_BEEF);
        idle();

        // Reset during a wait aborts it; the held request waits in full again.
        step(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
        check("rw_ack", 32'(seen_ack[1]), 32'd0);
        step(1'b1, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
        check("rw_instr", instr_b, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
            check("rw_post_ack", 32'(seen_ack[1]), 32'(i == 3));
        end
        idle();

        // Randomized traffic with mostly-held addresses so waits can complete.
        verbose = 1'b0;
        ra = 32'h1000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) ra = rand_addr();
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), ra,
                 ($urandom_range(0, 4) == 0), rand_addr(), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
